// File: rtl/bcd_sevenseg_scan.sv
// Three-digit multiplexed seven-segment driver with one-deep input holding register and frame-synchronous display update.
// seg/an/frame_done are registered one clock behind the scan state; in_ready drops on accept and returns the cycle after the frame boundary consumes the held value.
module bcd_sevenseg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        blank_zero,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYC);

  typedef enum logic [1:0] {
    SCAN_U = 2'd0,
    SCAN_T = 2'd1,
    SCAN_H = 2'd2
  } scan_t;

  scan_t         state;
  scan_t         state_nxt;
  logic [CW-1:0] cnt;
  logic          wrap;
  logic          boundary;
  logic          accept;
  logic [11:0]   pend_dat;
  logic          pend_vld;
  logic [11:0]   disp_dat;
  logic [3:0]    nib;
  logic          blank;
  logic [2:0]    an_dig;
  logic [6:0]    seg_nxt;
  logic [2:0]    an_nxt;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (state == SCAN_H);
  assign accept   = in_valid && in_ready;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= SCAN_U;
    end else begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    nib       = disp_dat[3:0];
    blank     = 1'b0;
    an_dig    = 3'b110;
    seg_nxt   = 7'h7F;
    an_nxt    = 3'b111;
    if (wrap) begin
      case (state)
        SCAN_U:  state_nxt = SCAN_T;
        SCAN_T:  state_nxt = SCAN_H;
        default: state_nxt = SCAN_U;
      endcase
    end
    case (state)
      SCAN_T: begin
        nib    = disp_dat[7:4];
        blank  = blank_zero && (disp_dat[11:8] == 4'd0) && (disp_dat[7:4] == 4'd0);
        an_dig = 3'b101;
      end
      SCAN_H: begin
        nib    = disp_dat[11:8];
        blank  = blank_zero && (disp_dat[11:8] == 4'd0);
        an_dig = 3'b011;
      end
      default: begin
        nib    = disp_dat[3:0];
        blank  = 1'b0;
        an_dig = 3'b110;
      end
    endcase
    // Blanking window at the head of each slot hides digit-switch ghosting
    if (cnt >= DEAD_END) begin
      an_nxt  = an_dig;
      seg_nxt = blank ? 7'h7F : dec7(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dat <= 12'h000;
      pend_vld <= 1'b0;
      disp_dat <= 12'h000;
      in_ready <= 1'b0;
    end else begin
      if (boundary && pend_vld) begin
        disp_dat <= pend_dat;
        pend_vld <= 1'b0;
      end
      if (accept) begin
        pend_dat <= bcd_in;
        pend_vld <= 1'b1;
      end
      // Stays low through the consuming edge so a new value never overwrites the held one
      in_ready <= ~(pend_vld | accept);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'h7F;
      an         <= 3'b111;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Bench for bcd_sevenseg_scan at REFRESH_DIV=8, DEAD_CYC=2: accepted values are queued with their expected frame and compared when that frame scans out.
module tb_bcd_sevenseg_scan;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        in_valid;
  logic        in_ready;
  logic        blank_zero;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] v;
    bit          bz;
  } exp_t;
  exp_t exp_q[$];

  logic [6:0]  obs_seg[24];
  logic [2:0]  obs_an[24];
  logic [23:0] obs_fd;
  logic [23:0] obs_rdy;
  logic        rdy_at_fd;

  bcd_sevenseg_scan #(.REFRESH_DIV(8), .DEAD_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .blank_zero (blank_zero),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, seg} for sample i (0..23) of a frame showing v.
  function automatic logic [9:0] exp_sample(input logic [11:0] v, input bit bz, input int i);
    int         slot;
    int         pos;
    logic [3:0] nib;
    logic [6:0] s;
    logic [2:0] a;
    bit         blank;
    slot = i / 8;
    pos  = i % 8;
    if (pos < 2) return {3'b111, 7'h7F};
    nib   = v[slot*4 +: 4];
    a     = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
    blank = bz && ((slot == 2 && v[11:8] == 4'd0) ||
                   (slot == 1 && v[11:8] == 4'd0 && v[7:4] == 4'd0));
    case (nib)
      4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
      4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
      4'd8: s = 7'h00;  4'd9: s = 7'h10;  default: s = 7'h3F;
    endcase
    if (blank) s = 7'h7F;
    return {a, s};
  endfunction

  task automatic drive_value(input logic [11:0] v);
    int n;
    n = 0;
    bcd_in   = v;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drive_wait in_ready=%b want 1 within 100 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_q.push_back('{v, blank_zero});
    end
  endtask

  task automatic capture(input bit wait_fd);
    int n;
    n = 0;
    if (wait_fd) begin
      do begin
        @(negedge clk);
        n++;
      end while (frame_done !== 1'b1 && n < 200);
      checks++;
      if (frame_done !== 1'b1) begin
        errors++;
        $display("FAIL frame_wait frame_done=%b want 1 within 200 cycles", frame_done);
      end
      rdy_at_fd = in_ready;
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      obs_seg[i] = seg;
      obs_an[i]  = an;
      obs_fd[i]  = frame_done;
      obs_rdy[i] = in_ready;
    end
  endtask

  task automatic test_reset;
    exp_t       e;
    logic [9:0] es;
    rst_n = 1'b0; in_valid = 1'b0; bcd_in = 12'h000; blank_zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, seg, an, frame_done} !== {1'b0, 7'h7F, 3'b111, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b seg=%h an=%b fd=%b want rdy=0 seg=7f an=111 fd=0",
               in_ready, seg, an, frame_done);
    end
    rst_n = 1'b1;
    exp_q.push_back('{12'h000, 1'b0});
    capture(1'b0);
    checks++;
    if (obs_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1 after first edge", obs_rdy[0]);
    end
    checks++;
    if (obs_fd !== 24'h800000) begin
      errors++;
      $display("FAIL reset_frame_done got %h want 800000", obs_fd);
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 24; i++) begin
      es = exp_sample(e.v, e.bz, i);
      checks++;
      if ({obs_an[i], obs_seg[i]} !== es) begin
        errors++;
        $display("FAIL reset_frame[%0d] got an=%b seg=%h want an=%b seg=%h",
                 i, obs_an[i], obs_seg[i], es[9:7], es[6:0]);
      end
    end
  endtask

  task automatic test_accept_mid_frame;
    exp_t       e;
    logic [9:0] es;
    bit         tear;
    int         n;
    tear = 1'b0;
    n    = 0;
    drive_value(12'h255);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_ready_low got %b want 0", in_ready);
    end
    while (frame_done !== 1'b1 && n < 200) begin
      if (an !== 3'b111 && seg !== 7'h40) tear = 1'b1;
      @(negedge clk);
      n++;
    end
    rdy_at_fd = in_ready;
    checks++;
    if (tear || n >= 200) begin
      errors++;
      $display("FAIL accept_no_tear got tear=%b wait=%0d want tear=0 wait<200", tear, n);
    end
    checks++;
    if (rdy_at_fd !== 1'b0) begin
      errors++;
      $display("FAIL accept_ready_at_boundary got %b want 0", rdy_at_fd);
    end
    capture(1'b0);
    checks++;
    if (obs_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready_after got %b want 1", obs_rdy[0]);
    end
    checks++;
    if (obs_fd !== 24'h800000) begin
      errors++;
      $display("FAIL accept_frame_done got %h want 800000", obs_fd);
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 24; i++) begin
      es = exp_sample(e.v, e.bz, i);
      checks++;
      if ({obs_an[i], obs_seg[i]} !== es) begin
        errors++;
        $display("FAIL accept_frame[%0d] got an=%b seg=%h want an=%b seg=%h",
                 i, obs_an[i], obs_seg[i], es[9:7], es[6:0]);
      end
    end
  endtask

  // Shared by the blanking and invalid-nibble scenarios: one value, one frame.
  task automatic test_digit_value(input logic [11:0] v, input bit bz);
    exp_t       e;
    logic [9:0] es;
    @(negedge clk);
    blank_zero = bz;
    drive_value(v);
    capture(1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 24; i++) begin
      es = exp_sample(e.v, e.bz, i);
      checks++;
      if ({obs_an[i], obs_seg[i]} !== es) begin
        errors++;
        $display("FAIL digit_%h_bz%0d[%0d] got an=%b seg=%h want an=%b seg=%h",
                 v, bz, i, obs_an[i], obs_seg[i], es[9:7], es[6:0]);
      end
    end
  endtask

  task automatic test_hold_while_busy;
    exp_t       e;
    logic [9:0] es;
    @(negedge clk);
    blank_zero = 1'b0;
    drive_value(12'h111);
    bcd_in   = 12'h222;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready[%0d] got %b want 0", k, in_ready);
      end
    end
    in_valid = 1'b0;
    capture(1'b1);
    drive_value(12'h222);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) capture(1'b1);
      e = exp_q.pop_front();
      for (int i = 0; i < 24; i++) begin
        es = exp_sample(e.v, e.bz, i);
        checks++;
        if ({obs_an[i], obs_seg[i]} !== es) begin
          errors++;
          $display("FAIL hold_frame%0d[%0d] got an=%b seg=%h want an=%b seg=%h",
                   f, i, obs_an[i], obs_seg[i], es[9:7], es[6:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    exp_t       e;
    logic [9:0] es;
    int         n;
    n = 0;
    @(negedge clk);
    blank_zero = 1'b1;
    drive_value(12'h456);
    while (an !== 3'b101 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (an !== 3'b101) begin
      errors++;
      $display("FAIL rst_wait_tens got an=%b want 101 within 100 cycles", an);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, seg, an, frame_done} !== {1'b0, 7'h7F, 3'b111, 1'b0}) begin
      errors++;
      $display("FAIL rst_async got rdy=%b seg=%h an=%b fd=%b want rdy=0 seg=7f an=111 fd=0",
               in_ready, seg, an, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back('{12'h000, 1'b1});
    exp_q.push_back('{12'h000, 1'b1});
    for (int f = 0; f < 2; f++) begin
      capture(f == 1);
      if (f == 0) begin
        checks++;
        if (obs_rdy[0] !== 1'b1) begin
          errors++;
          $display("FAIL rst_ready got %b want 1 after first edge", obs_rdy[0]);
        end
      end
      e = exp_q.pop_front();
      for (int i = 0; i < 24; i++) begin
        es = exp_sample(e.v, e.bz, i);
        checks++;
        if ({obs_an[i], obs_seg[i]} !== es) begin
          errors++;
          $display("FAIL rst_frame%0d[%0d] got an=%b seg=%h want an=%b seg=%h",
                   f, i, obs_an[i], obs_seg[i], es[9:7], es[6:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept_mid_frame();
    test_digit_value(12'h007, 1'b1);
    test_digit_value(12'h1A3, 1'b1);
    test_digit_value(12'h1A3, 1'b0);
    test_hold_while_busy();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete within 400000 time units");
    $fatal(1);
  end

endmodule
